// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 machine-cycle sequencer.
// Imported by the interface, the refresh counter and the top level.
package z80_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic STROBE_OFF = 1'b1;
  localparam logic STROBE_ON  = 1'b0;

  typedef enum logic [1:0] {
    KIND_FETCH = 2'd0,
    KIND_READ  = 2'd1,
    KIND_WRITE = 2'd2,
    KIND_RSVD  = 2'd3
  } req_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TW   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5
  } tstate_e;

  typedef struct packed {
    req_kind_e           kind;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
  } req_t;

  // Last T-state of a machine cycle: a new request may be accepted here.
  function automatic logic is_final_state(input tstate_e st, input req_kind_e kind,
                                          input logic refresh_en);
    logic fin;
    if (st == ST_T4) begin
      fin = 1'b1;
    end else if (st == ST_T3) begin
      fin = !((kind == KIND_FETCH) && refresh_en);
    end else begin
      fin = 1'b0;
    end
    return fin;
  endfunction

endpackage

// File: rtl/z80_bus_cycle_ctrl_if.sv
// Core request/response, refresh-register and memory-bus bundle of the sequencer.
// The slave modport is the sequencer; the master modport is the core plus memory.
interface z80_bus_cycle_ctrl_if;
  import z80_bus_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_kind;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic [DATA_W-1:0] i_reg;
  logic              r_load;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_value;
  logic              wait_;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic [DATA_W-1:0] imem_data1;
  logic              imem_RD_;
  logic              imem_WR_;
  logic              imem_MREQ_;
  logic              m1_;
  logic              rfsh_;

  modport slave (
    input  req_valid, req_kind, req_addr, req_wdata, i_reg, r_load, r_wdata,
           wait_, imem_data,
    output req_ready, resp_valid, resp_data, r_value, imem_addr, imem_data1,
           imem_RD_, imem_WR_, imem_MREQ_, m1_, rfsh_
  );

  modport master (
    output req_valid, req_kind, req_addr, req_wdata, i_reg, r_load, r_wdata,
           wait_, imem_data,
    input  req_ready, resp_valid, resp_data, r_value, imem_addr, imem_data1,
           imem_RD_, imem_WR_, imem_MREQ_, m1_, rfsh_
  );

endinterface

// File: rtl/z80_refresh_counter.sv
// Z80 R register: 7-bit refresh count with bit 7 preserved; a load beats the increment.
module z80_refresh_counter
  import z80_bus_pkg::*;
#(
  parameter logic [DATA_W-1:0] R_RESET = 8'h00
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inc,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] r_value
);

  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] r_d;

  // Next R value: load has priority over the end-of-T4 increment.
  always_comb begin
    r_d = r_q;
    if (load) begin
      r_d = load_data;
    end else if (inc) begin
      r_d = {r_q[7], r_q[6:0] + 7'd1};
    end else begin
      r_d = r_q;
    end
  end

  // R register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q <= R_RESET;
    end else begin
      r_q <= r_d;
    end
  end

  assign r_value = r_q;

endmodule

// File: rtl/z80_bus_cycle_ctrl.sv
// Z80 machine-cycle sequencer: turns fetch/read/write requests into T-state strobe
// sequences. Outputs are registered from the next state so they align with the state.
module z80_bus_cycle_ctrl
  import z80_bus_pkg::*;
#(
  parameter bit                REFRESH_EN = 1'b1,
  parameter logic [DATA_W-1:0] R_RESET    = 8'h00
) (
  input  logic                 clock,
  input  logic                 reset,
  z80_bus_cycle_ctrl_if.slave  io
);

  tstate_e           state_q, state_d;
  req_t              req_q, req_d;
  logic              accept;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_valid_q, resp_valid_d;
  logic              ready_q, ready_d;
  logic              mreq_q, mreq_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              m1_q, m1_d;
  logic              rfsh_q, rfsh_d;

  logic              refresh_fetch;
  logic [DATA_W-1:0] r_value;
  logic              r_inc;

  assign r_inc = (state_q == ST_T4);

  z80_refresh_counter #(
    .R_RESET (R_RESET)
  ) u_refresh (
    .clock     (clock),
    .reset     (reset),
    .inc       (r_inc),
    .load      (io.r_load),
    .load_data (io.r_wdata),
    .r_value   (r_value)
  );

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      req_q        <= '{kind: KIND_FETCH, addr: 16'h0000, wdata: 8'h00};
      addr_q       <= 16'h0000;
      data1_q      <= 8'h00;
      resp_data_q  <= 8'h00;
      resp_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      mreq_q       <= STROBE_OFF;
      rd_q         <= STROBE_OFF;
      wr_q         <= STROBE_OFF;
      m1_q         <= STROBE_OFF;
      rfsh_q       <= STROBE_OFF;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      data1_q      <= data1_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      ready_q      <= ready_d;
      mreq_q       <= mreq_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      m1_q         <= m1_d;
      rfsh_q       <= rfsh_d;
    end
  end

  // Next-state logic and request latching.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    accept  = io.req_valid && ready_q && (io.req_kind != KIND_RSVD);

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_T1;
        else        state_d = ST_IDLE;
      end
      ST_T1: state_d = ST_T2;
      ST_T2, ST_TW: begin
        if (io.wait_) state_d = ST_T3;
        else          state_d = ST_TW;
      end
      ST_T3: begin
        if ((req_q.kind == KIND_FETCH) && REFRESH_EN) state_d = ST_T4;
        else if (accept)                              state_d = ST_T1;
        else                                          state_d = ST_IDLE;
      end
      ST_T4: begin
        if (accept) state_d = ST_T1;
        else        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      req_d = '{kind: req_kind_e'(io.req_kind), addr: io.req_addr, wdata: io.req_wdata};
    end else begin
      req_d = req_q;
    end
  end

  // Output values for the state being entered.
  always_comb begin
    addr_d        = addr_q;
    data1_d       = data1_q;
    mreq_d        = STROBE_OFF;
    rd_d          = STROBE_OFF;
    wr_d          = STROBE_OFF;
    m1_d          = STROBE_OFF;
    rfsh_d        = STROBE_OFF;
    refresh_fetch = (req_d.kind == KIND_FETCH) && REFRESH_EN;
    resp_valid_d  = (state_d == ST_T3);
    ready_d       = (state_d == ST_IDLE) || is_final_state(state_d, req_d.kind, REFRESH_EN);

    // Capture read data on the edge that closes T2 or the last wait state.
    if (((state_q == ST_T2) || (state_q == ST_TW)) && (state_d == ST_T3)) begin
      resp_data_d = io.imem_data;
    end else begin
      resp_data_d = resp_data_q;
    end

    case (state_d)
      ST_T1, ST_T2, ST_TW, ST_T3: begin
        if ((state_d == ST_T3) && refresh_fetch) begin
          addr_d = {io.i_reg, r_value};
          rfsh_d = STROBE_ON;
        end else begin
          addr_d = req_d.addr;
          mreq_d = STROBE_ON;
          rd_d   = (req_d.kind == KIND_WRITE) ? STROBE_OFF : STROBE_ON;
          m1_d   = (req_d.kind == KIND_FETCH) ? STROBE_ON : STROBE_OFF;
          if (req_d.kind == KIND_WRITE) begin
            data1_d = req_d.wdata;
            wr_d    = (state_d == ST_T1) ? STROBE_OFF : STROBE_ON;
          end else begin
            data1_d = data1_q;
          end
        end
      end
      ST_T4: begin
        addr_d = {io.i_reg, r_value};
        mreq_d = STROBE_ON;
        rfsh_d = STROBE_ON;
      end
      default: begin
        addr_d = addr_q;
      end
    endcase
  end

  assign io.req_ready  = ready_q;
  assign io.resp_valid = resp_valid_q;
  assign io.resp_data  = resp_data_q;
  assign io.r_value    = r_value;
  assign io.imem_addr  = addr_q;
  assign io.imem_data1 = data1_q;
  assign io.imem_MREQ_ = mreq_q;
  assign io.imem_RD_   = rd_q;
  assign io.imem_WR_   = wr_q;
  assign io.m1_        = m1_q;
  assign io.rfsh_      = rfsh_q;

endmodule

// File: tb/tb_z80_bus_cycle_ctrl.sv
// Directed bench for z80_bus_cycle_ctrl; strobe vectors are {MREQ_, RD_, WR_, M1_, RFSH_}.
module tb_z80_bus_cycle_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  z80_bus_cycle_ctrl_if bus ();

  z80_bus_cycle_ctrl #(
    .REFRESH_EN (1'b1),
    .R_RESET    (8'h00)
  ) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [4:0] strb();
    return {bus.imem_MREQ_, bus.imem_RD_, bus.imem_WR_, bus.m1_, bus.rfsh_};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_kind  = 2'd0;
    bus.req_addr  = 16'h0000;
    bus.req_wdata = 8'h00;
    bus.i_reg     = 8'h00;
    bus.r_load    = 1'b0;
    bus.r_wdata   = 8'h00;
    bus.wait_     = 1'b1;
    bus.imem_data = 8'h00;
  endtask

  task automatic request(input logic [1:0] k, input logic [15:0] a, input logic [7:0] d);
    bus.req_valid = 1'b1;
    bus.req_kind  = k;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready); end
    n_tests++; if (bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h expected 0000", bus.imem_addr); end
    n_tests++; if (bus.imem_data1 !== 8'h00) begin n_fail++; $display("FAIL reset_data1: got %h expected 00", bus.imem_data1); end
    n_tests++; if (bus.resp_data !== 8'h00) begin n_fail++; $display("FAIL reset_resp_data: got %h expected 00", bus.resp_data); end
    n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
    n_tests++; if (strb() !== 5'b11111) begin n_fail++; $display("FAIL reset_strobes: got %b expected 11111", strb()); end
    n_tests++; if (bus.r_value !== 8'h00) begin n_fail++; $display("FAIL reset_r: got %h expected 00", bus.r_value); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_read();
    logic [4:0] exp_strb [4] = '{5'b00111, 5'b00111, 5'b00111, 5'b11111};
    logic       exp_rv   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_rdy  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    bus.imem_data = 8'hA5;
    request(2'd1, 16'h1234, 8'h00);
    step();
    bus.req_valid = 1'b0;
    bus.req_addr  = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (strb() !== exp_strb[i]) begin n_fail++; $display("FAIL read_strobes[%0d]: got %b expected %b", i, strb(), exp_strb[i]); end
      n_tests++; if (bus.resp_valid !== exp_rv[i]) begin n_fail++; $display("FAIL read_resp_valid[%0d]: got %b expected %b", i, bus.resp_valid, exp_rv[i]); end
      n_tests++; if (bus.req_ready !== exp_rdy[i]) begin n_fail++; $display("FAIL read_ready[%0d]: got %b expected %b", i, bus.req_ready, exp_rdy[i]); end
      n_tests++; if (bus.imem_addr !== 16'h1234) begin n_fail++; $display("FAIL read_addr[%0d]: got %h expected 1234", i, bus.imem_addr); end
      if (i >= 2) begin
        n_tests++; if (bus.resp_data !== 8'hA5) begin n_fail++; $display("FAIL read_data[%0d]: got %h expected a5", i, bus.resp_data); end
      end
      step();
    end
  endtask

  task automatic test_fetch();
    logic [4:0]  exp_strb [5] = '{5'b00101, 5'b00101, 5'b11110, 5'b01110, 5'b11111};
    logic [15:0] exp_addr [5] = '{16'h0000, 16'h0000, 16'h3F7F, 16'h3F7F, 16'h3F7F};
    logic        exp_rv   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        exp_rdy  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.r_load  = 1'b1;
    bus.r_wdata = 8'h7F;
    step();
    bus.r_load  = 1'b0;
    n_tests++; if (bus.r_value !== 8'h7F) begin n_fail++; $display("FAIL fetch_r_load: got %h expected 7f", bus.r_value); end
    bus.i_reg     = 8'h3F;
    bus.imem_data = 8'hC3;
    request(2'd0, 16'h0000, 8'h00);
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (strb() !== exp_strb[i]) begin n_fail++; $display("FAIL fetch_strobes[%0d]: got %b expected %b", i, strb(), exp_strb[i]); end
      n_tests++; if (bus.imem_addr !== exp_addr[i]) begin n_fail++; $display("FAIL fetch_addr[%0d]: got %h expected %h", i, bus.imem_addr, exp_addr[i]); end
      n_tests++; if (bus.resp_valid !== exp_rv[i]) begin n_fail++; $display("FAIL fetch_resp_valid[%0d]: got %b expected %b", i, bus.resp_valid, exp_rv[i]); end
      n_tests++; if (bus.req_ready !== exp_rdy[i]) begin n_fail++; $display("FAIL fetch_ready[%0d]: got %b expected %b", i, bus.req_ready, exp_rdy[i]); end
      if (i == 2) begin
        n_tests++; if (bus.resp_data !== 8'hC3) begin n_fail++; $display("FAIL fetch_data: got %h expected c3", bus.resp_data); end
      end
      if (i == 4) begin
        n_tests++; if (bus.r_value !== 8'h00) begin n_fail++; $display("FAIL fetch_r_wrap: got %h expected 00", bus.r_value); end
      end
      step();
    end
  endtask

  task automatic test_write();
    logic [4:0] exp_strb [6] = '{5'b01111, 5'b01011, 5'b01011, 5'b01011, 5'b01011, 5'b11111};
    logic       exp_rv   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bus.imem_data = 8'h00;
    request(2'd2, 16'h8000, 8'h5A);
    step();
    bus.req_valid = 1'b0;
    bus.req_wdata = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      bus.wait_ = (i == 1 || i == 2) ? 1'b0 : 1'b1;
      n_tests++; if (strb() !== exp_strb[i]) begin n_fail++; $display("FAIL write_strobes[%0d]: got %b expected %b", i, strb(), exp_strb[i]); end
      n_tests++; if (bus.resp_valid !== exp_rv[i]) begin n_fail++; $display("FAIL write_resp_valid[%0d]: got %b expected %b", i, bus.resp_valid, exp_rv[i]); end
      if (i < 5) begin
        n_tests++; if (bus.imem_data1 !== 8'h5A) begin n_fail++; $display("FAIL write_data1[%0d]: got %h expected 5a", i, bus.imem_data1); end
        n_tests++; if (bus.imem_addr !== 16'h8000) begin n_fail++; $display("FAIL write_addr[%0d]: got %h expected 8000", i, bus.imem_addr); end
      end
      step();
    end
    bus.wait_ = 1'b1;
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    bus.i_reg     = 8'h12;
    bus.imem_data = 8'h3E;
    request(2'd0, 16'h0100, 8'h00);
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < 7 && bus.resp_valid === 1'b1) pulses++;
      if (i == 2) begin
        n_tests++; if (bus.resp_data !== 8'h3E) begin n_fail++; $display("FAIL b2b_fetch_data: got %h expected 3e", bus.resp_data); end
      end
      if (i == 3) begin
        n_tests++; if (strb() !== 5'b01110) begin n_fail++; $display("FAIL b2b_t4_strobes: got %b expected 01110", strb()); end
        request(2'd1, 16'h4000, 8'h00);
        bus.imem_data = 8'h77;
      end
      if (i == 4) begin
        bus.req_valid = 1'b0;
        n_tests++; if (bus.imem_addr !== 16'h4000) begin n_fail++; $display("FAIL b2b_read_addr: got %h expected 4000", bus.imem_addr); end
        n_tests++; if (strb() !== 5'b00111) begin n_fail++; $display("FAIL b2b_read_t1_strobes: got %b expected 00111", strb()); end
      end
      if (i == 6) begin
        n_tests++; if (bus.resp_data !== 8'h77) begin n_fail++; $display("FAIL b2b_read_data: got %h expected 77", bus.resp_data); end
      end
      if (i == 7) begin
        n_tests++; if (strb() !== 5'b11111) begin n_fail++; $display("FAIL b2b_idle_strobes: got %b expected 11111", strb()); end
      end
      step();
    end
    n_tests++; if (pulses != 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
    n_tests++; if (bus.r_value !== 8'h01) begin n_fail++; $display("FAIL b2b_r: got %h expected 01", bus.r_value); end
  endtask

  task automatic test_r_wrap();
    bus.r_load  = 1'b1;
    bus.r_wdata = 8'hFF;
    step();
    bus.r_load  = 1'b0;
    request(2'd0, 16'h2000, 8'h00);
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_tests++; if (bus.r_value !== 8'h80) begin n_fail++; $display("FAIL r_bit7_preserve: got %h expected 80", bus.r_value); end
    request(2'd0, 16'h2001, 8'h00);
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_tests++; if (strb() !== 5'b01110) begin n_fail++; $display("FAIL r_load_t4_strobes: got %b expected 01110", strb()); end
    bus.r_load  = 1'b1;
    bus.r_wdata = 8'h10;
    step();
    bus.r_load  = 1'b0;
    n_tests++; if (bus.r_value !== 8'h10) begin n_fail++; $display("FAIL r_load_priority: got %h expected 10", bus.r_value); end
  endtask

  task automatic test_reserved();
    request(2'd3, 16'h1111, 8'h00);
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rsvd_ready[%0d]: got %b expected 1", i, bus.req_ready); end
      n_tests++; if (strb() !== 5'b11111) begin n_fail++; $display("FAIL rsvd_strobes[%0d]: got %b expected 11111", i, strb()); end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.wait_ = 1'b0;
    request(2'd2, 16'hABCD, 8'h99);
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    n_tests++; if (strb() !== 5'b01011) begin n_fail++; $display("FAIL midrst_tw_strobes: got %b expected 01011", strb()); end
    #2;
    reset = 1'b1;
    #1;
    n_tests++; if (bus.imem_WR_ !== 1'b1) begin n_fail++; $display("FAIL midrst_wr_async: got %b expected 1", bus.imem_WR_); end
    n_tests++; if (bus.imem_MREQ_ !== 1'b1) begin n_fail++; $display("FAIL midrst_mreq_async: got %b expected 1", bus.imem_MREQ_); end
    step();
    step();
    n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_resp_valid: got %b expected 0", bus.resp_valid); end
    reset     = 1'b0;
    bus.wait_ = 1'b1;
    n_tests++; if (bus.r_value !== 8'h00) begin n_fail++; $display("FAIL midrst_r: got %h expected 00", bus.r_value); end
    step();
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", bus.req_ready); end
    n_tests++; if (strb() !== 5'b11111) begin n_fail++; $display("FAIL midrst_strobes: got %b expected 11111", strb()); end
    n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_resp: got %b expected 0", bus.resp_valid); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_fetch();
    test_write();
    test_back_to_back();
    test_r_wrap();
    test_reserved();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/z80_bus_cycle_ctrl.md
Name: z80_bus_cycle_ctrl

Overview:
- Machine-cycle sequencer between the CPU core's execution control and the instruction/data memory.
- Turns one-shot core requests (opcode fetch, memory read, memory write) into Z80-style T-state sequences. Drives the memory's 16-bit address, 8-bit write data and active-low MREQ_/RD_/WR_ strobes, plus M1_/RFSH_.
- Returns read or fetched bytes to the core and owns the refresh (R) counter.

Parameters:
- REFRESH_EN, 1, 1 = fetch cycles include T3/T4 refresh; 0 = fetch ends after T3 with no refresh strobe.
- R_RESET, 8'h00, reset value of the R register.

Ports:
- clock  in  1  single system clock; one clock = one T-state
- reset  in  1  asynchronous, active-high
- io_req_valid  in  1  core requests a machine cycle
- io_req_ready  out  1  sequencer accepts a request this cycle
- io_req_kind  in  2  0 = fetch, 1 = read, 2 = write, 3 = reserved (ignored, never accepted)
- io_req_addr  in  16  cycle address
- io_req_wdata  in  8  write data
- io_resp_valid  out  1  one-cycle pulse: cycle data captured / write done
- io_resp_data  out  8  captured byte; holds until the next capture
- io_i_reg  in  8  I register, high byte of the refresh address
- io_r_load  in  1  load R (LD R,A)
- io_r_wdata  in  8  value for R load
- io_r_value  out  8  current R
- io_wait_  in  1  active-low wait from memory
- io_imem_addr  out  16  memory address
- io_imem_data  in  8  memory read data
- io_imem_data1  out  8  memory write data
- io_imem_RD_  out  1  active-low read strobe
- io_imem_WR_  out  1  active-low write strobe
- io_imem_MREQ_  out  1  active-low memory request
- io_m1_  out  1  active-low opcode-fetch marker
- io_rfsh_  out  1  active-low refresh marker

Behaviour:
- Reset (async, immediate, also mid-cycle):
  - State returns to IDLE; the cycle in flight is abandoned with no resp_valid.
  - io_imem_addr = 0, data1 = 0, resp_data = 0, resp_valid = 0.
  - All active-low strobes = 1; R = R_RESET.
- State machine: IDLE, T1, T2, TW, T3, T4. All outputs are registered from state and latched request fields.
- io_req_ready = 1 in IDLE and in the final T-state of a cycle (T3 for read/write, or for fetch with REFRESH_EN=0; T4 for fetch).
  - Acceptance = valid & ready & kind != 3.
  - Acceptance in a final state enters T1 on the next clock (back-to-back, no idle gap).
  - Request fields are latched on acceptance; later input changes are ignored.
- IDLE: addr holds its last value; all strobes high.
- T1:
  - addr = latched address.
  - MREQ_ = 0; RD_ = 0 for fetch/read.
  - M1_ = 0 for fetch.
  - data1 = wdata for write.
- T2:
  - Strobes as in T1; WR_ = 0 for write.
  - io_wait_ is sampled at the end of T2: 0 goes to TW, 1 goes to T3.
- TW: same outputs as T2. Stays in TW while io_wait_ = 0; leaves to T3 on the first cycle it samples 1. Wait length is unbounded.
- Read data capture: on the T2/TW to T3 transition, resp_data <= io_imem_data. resp_valid = 1 for exactly the T3 cycle (fetch, read and write alike).
- T3, read/write:
  - Strobes as in T2; write data still driven.
  - Next state: T1 if a request is accepted, otherwise IDLE.
- T3/T4, fetch with REFRESH_EN = 1:
  - addr = {io_i_reg, R}; MREQ_ = 1 in T3, 0 in T4.
  - RD_ = 1, M1_ = 1, RFSH_ = 0 in both T3 and T4.
  - Wait is not sampled.
  - At the end of T4, R[6:0] increments modulo 128 and R[7] is preserved (8'h7F to 8'h00, 8'hFF to 8'h80).
- io_r_load: R <= io_r_wdata next clock. If it coincides with the T4 increment, the load wins.
- Write cycles never assert RD_; read and fetch cycles never assert WR_.

Decomposition:
- Shared package (z80_bus_pkg):
  - Request-kind encodings FETCH/READ/WRITE.
  - T-state enum.
  - Strobe inactive level constant (1).
- Natural sub-module: z80_refresh_counter (R register with 7-bit wrap, bit-7 preserve, load priority).

Test Plan:
- Read 0x1234, memory returns 0xA5, wait_ = 1:
  - MREQ_/RD_ low in T1–T3.
  - resp_valid exactly in T3 with resp_data = 0xA5.
  - Back to IDLE after 3 clocks.
- Fetch 0x0000, I = 0x3F, R = 0x7F, memory returns 0xC3:
  - M1_ low in T1–T2; data 0xC3.
  - T3/T4 addr = 0x3F7F, RFSH_ low, MREQ_ low only in T4.
  - R = 0x00 afterwards.
- Write 0x8000 data 0x5A with wait_ = 0 for 2 cycles:
  - States T1, T2, TW, TW, T3.
  - WR_ low T2 through T3, RD_ never low, data1 = 0x5A throughout.
- Back-to-back: fetch accepted in IDLE, read accepted in fetch T4:
  - Read T1 directly follows T4.
  - Total 7 clocks; two resp_valid pulses.
- R = 0xFF plus fetch: R becomes 0x80. r_load 0x10 coincident with T4: R = 0x10.
- Reset asserted during TW of a write:
  - WR_/MREQ_ go high immediately (before the next clock edge).
  - No resp_valid; after release, ready = 1 and R = R_RESET.
